alucc_ctl: RTL and testbench

//   ALU carry/condition-code stage paired with the 32-bit ALP bitslice array in the DPM.
//   - Consumes nibble generate/propagate (p_l/g_l), the per-byte zero and overflow flags and
//     the WBUS sign bits.
//   - Returns the 8 nibble carry-ins (aluc_l) through an 8-nibble lookahead.
//   - Holds the registered ALU condition codes N/Z/V/C, selected by data size.
//   - Holds the 6-bit step counter used by multiply/divide/shift loops.

---
 rtl/dpm_pkg.sv | 29 ++
 rtl/dpm_cla8.sv | 30 +++
 rtl/alucc_ctl.sv | 170 +++++++++++++++++
 tb/tb_alucc_ctl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpm_pkg.sv
// -----------------------------------------------------------------------------
// dpm_pkg
//   Shared encodings for the DPM ALU carry/condition-code stage.
//   - Data size codes for d_size_h (any 1x code selects long).
//   - Carry-in select codes for cin_sel_h.
//   - nzvc_t condition-code vector and its bit positions.
// -----------------------------------------------------------------------------
package dpm_pkg;

   localparam logic [1:0] DSZ_BYTE = 2'b00;
   localparam logic [1:0] DSZ_WORD = 2'b01;
   localparam logic [1:0] DSZ_LONG = 2'b10;

   localparam logic [1:0] CIN_ZERO = 2'b00;
   localparam logic [1:0] CIN_ONE  = 2'b01;
   localparam logic [1:0] CIN_ALUC = 2'b10;
   localparam logic [1:0] CIN_EXT  = 2'b11;

   typedef logic [3:0] nzvc_t;

   localparam int NZVC_N = 3;
   localparam int NZVC_Z = 2;
   localparam int NZVC_V = 1;
   localparam int NZVC_C = 0;

   // Z set, everything else clear
   localparam nzvc_t NZVC_RESET = 4'b0100;

endpackage

// File: rtl/dpm_cla8.sv
// -----------------------------------------------------------------------------
// dpm_cla8
//   Pure combinational 8-nibble carry lookahead, active-high throughout.
// Ports:
//   p   in  8  nibble propagate, [n] = nibble n
//   g   in  8  nibble generate
//   c0  in  1  carry into nibble 0
//   c   out 9  c[n] = carry into nibble n, c[8] = carry out of nibble 7
// -----------------------------------------------------------------------------
module dpm_cla8 (
   input  logic [7:0] p,
   input  logic [7:0] g,
   input  logic       c0,
   output logic [8:0] c
);

   logic carry;

   // Ripple the lookahead equation through the eight nibbles
   always_comb begin
      carry = c0;
      c     = 9'b0_0000_0000;
      c[0]  = c0;
      for (int i = 0; i < 8; i++) begin
         carry    = g[i] | (p[i] & carry);
         c[i + 1] = carry;
      end
   end

endmodule

// File: rtl/alucc_ctl.sv
// -----------------------------------------------------------------------------
// alucc_ctl
//   ALU carry / condition-code stage for the 32-bit ALP bitslice array.
//   Returns nibble carry-ins via an 8-nibble lookahead, holds the registered
//   N/Z/V/C selected by data size, and an optional step counter for
//   multiply/divide/shift loops.
// Configuration:
//   ALUCC_STEP_CNT_EN  defined   -> step counter present
//                      undefined -> no counter, sc_* inputs ignored,
//                                   sc_zero_h tied to 1
// Ports:
//   qdck_l      in   clock, rising edge
//   reset_l     in   synchronous active-low reset
//   p_l, g_l    in   nibble propagate/generate, active-low
//   aluc_l      out  carry into nibble n, active-low, combinational
//   wmuxz_h     in   byte k of WBUS is zero
//   aluv_h      in   signed overflow out of byte k
//   wsign_h     in   WBUS bits {31,15,7}
//   d_size_h    in   00 byte, 01 word, 1x long
//   cin_sel_h   in   carry-in select (zero, one, registered C, external)
//   cin_ext_h   in   external carry-in
//   cc_ld_h     in   load N/Z/V/C
//   zacc_h      in   accumulate Z across multi-precision operations
//   sc_ld_h     in   load step counter
//   sc_dec_h    in   decrement step counter (saturates at 0)
//   sc_d_h      in   step counter load value
//   alu_nzvc_h  out  registered {N,Z,V,C}
//   sc_zero_h   out  step counter == 0
// -----------------------------------------------------------------------------
module alucc_ctl
   import dpm_pkg::*;
#(
   parameter int SC_W = 6
) (
   input  logic            qdck_l,
   input  logic            reset_l,
   input  logic [7:0]      p_l,
   input  logic [7:0]      g_l,
   output logic [7:0]      aluc_l,
   input  logic [3:0]      wmuxz_h,
   input  logic [3:0]      aluv_h,
   input  logic [2:0]      wsign_h,
   input  logic [1:0]      d_size_h,
   input  logic [1:0]      cin_sel_h,
   input  logic            cin_ext_h,
   input  logic            cc_ld_h,
   input  logic            zacc_h,
   input  logic            sc_ld_h,
   input  logic            sc_dec_h,
   input  logic [SC_W-1:0] sc_d_h,
   output logic [3:0]      alu_nzvc_h,
   output logic            sc_zero_h
);

   logic [8:0] carry;
   logic       cin;
   nzvc_t      cc_reg;
   nzvc_t      cc_next;
   logic       sel_n;
   logic       sel_zn;
   logic       sel_v;
   logic       sel_c;
   logic       unused_aluv2;

   // Byte 2 overflow has no size that selects it
   assign unused_aluv2 = aluv_h[2];

   // Carry-in select; CIN_ALUC reads the flop, so a same-cycle C reload
   // cannot form a loop through the lookahead
   always_comb begin
      cin = 1'b0;
      case (cin_sel_h)
         CIN_ZERO: cin = 1'b0;
         CIN_ONE:  cin = 1'b1;
         CIN_ALUC: cin = cc_reg[NZVC_C];
         CIN_EXT:  cin = cin_ext_h;
         default:  cin = 1'b0;
      endcase
   end

   dpm_cla8 u_cla (
      .p  (~p_l),
      .g  (~g_l),
      .c0 (cin),
      .c  (carry)
   );

   assign aluc_l = ~carry[7:0];

   // Pick the flag sources for the active data size
   always_comb begin
      sel_n  = wsign_h[2];
      sel_zn = &wmuxz_h;
      sel_v  = aluv_h[3];
      sel_c  = carry[8];
      case (d_size_h)
         DSZ_BYTE: begin
            sel_n  = wsign_h[0];
            sel_zn = wmuxz_h[0];
            sel_v  = aluv_h[0];
            sel_c  = carry[2];
         end
         DSZ_WORD: begin
            sel_n  = wsign_h[1];
            sel_zn = &wmuxz_h[1:0];
            sel_v  = aluv_h[1];
            sel_c  = carry[4];
         end
         default: begin
            sel_n  = wsign_h[2];
            sel_zn = &wmuxz_h;
            sel_v  = aluv_h[3];
            sel_c  = carry[8];
         end
      endcase
   end

   // Next condition codes; zacc_h ANDs the new Z into the old one
   always_comb begin
      cc_next = cc_reg;
      if (cc_ld_h) begin
         cc_next[NZVC_N] = sel_n;
         cc_next[NZVC_V] = sel_v;
         cc_next[NZVC_C] = sel_c;
         if (zacc_h) begin
            cc_next[NZVC_Z] = sel_zn & cc_reg[NZVC_Z];
         end else begin
            cc_next[NZVC_Z] = sel_zn;
         end
      end else begin
         cc_next = cc_reg;
      end
   end

   // Condition-code register
   always_ff @(posedge qdck_l) begin
      if (!reset_l) begin
         cc_reg <= NZVC_RESET;
      end else begin
         cc_reg <= cc_next;
      end
   end

   assign alu_nzvc_h = cc_reg;

`ifdef ALUCC_STEP_CNT_EN
   logic [SC_W-1:0] step_cnt;

   // Step counter: load beats decrement, decrement saturates at zero
   always_ff @(posedge qdck_l) begin
      if (!reset_l) begin
         step_cnt <= {SC_W{1'b0}};
      end else if (sc_ld_h) begin
         step_cnt <= sc_d_h;
      end else if (sc_dec_h && (step_cnt != {SC_W{1'b0}})) begin
         step_cnt <= step_cnt - {{(SC_W-1){1'b0}}, 1'b1};
      end else begin
         step_cnt <= step_cnt;
      end
   end

   assign sc_zero_h = (step_cnt == {SC_W{1'b0}});
`else
   logic unused_sc;

   assign unused_sc = ^{sc_ld_h, sc_dec_h, sc_d_h};
   assign sc_zero_h = 1'b1;
`endif

endmodule

// File: tb/tb_alucc_ctl.sv
// -----------------------------------------------------------------------------
// tb_alucc_ctl
//   Scoreboard bench for alucc_ctl. A behavioural model pushes expected
//   carries, condition codes and sc_zero_h as stimulus is applied; each test
//   task pops and compares them when the DUT output is due.
//   Follows ALUCC_STEP_CNT_EN for the expected step-counter behaviour.
// -----------------------------------------------------------------------------
module tb_alucc_ctl;

   localparam int SC_W = 6;

   logic            qdck_l = 1'b0;
   logic            reset_l = 1'b0;
   logic [7:0]      p_l = 8'hFF;
   logic [7:0]      g_l = 8'hFF;
   logic [7:0]      aluc_l;
   logic [3:0]      wmuxz_h = 4'h0;
   logic [3:0]      aluv_h = 4'h0;
   logic [2:0]      wsign_h = 3'b000;
   logic [1:0]      d_size_h = 2'b00;
   logic [1:0]      cin_sel_h = 2'b00;
   logic            cin_ext_h = 1'b0;
   logic            cc_ld_h = 1'b0;
   logic            zacc_h = 1'b0;
   logic            sc_ld_h = 1'b0;
   logic            sc_dec_h = 1'b0;
   logic [SC_W-1:0] sc_d_h = 6'd0;
   logic [3:0]      alu_nzvc_h;
   logic            sc_zero_h;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_aluc_q[$];
   logic [3:0] exp_cc_q[$];
   logic       exp_scz_q[$];

   logic [3:0]      m_nzvc = 4'b0100;
   logic [SC_W-1:0] m_cnt = 6'd0;
   logic [7:0]      exp8;
   logic [3:0]      exp4;
   logic            expb;

   alucc_ctl #(.SC_W(SC_W)) dut (
      .qdck_l     (qdck_l),
      .reset_l    (reset_l),
      .p_l        (p_l),
      .g_l        (g_l),
      .aluc_l     (aluc_l),
      .wmuxz_h    (wmuxz_h),
      .aluv_h     (aluv_h),
      .wsign_h    (wsign_h),
      .d_size_h   (d_size_h),
      .cin_sel_h  (cin_sel_h),
      .cin_ext_h  (cin_ext_h),
      .cc_ld_h    (cc_ld_h),
      .zacc_h     (zacc_h),
      .sc_ld_h    (sc_ld_h),
      .sc_dec_h   (sc_dec_h),
      .sc_d_h     (sc_d_h),
      .alu_nzvc_h (alu_nzvc_h),
      .sc_zero_h  (sc_zero_h)
   );

   always #5 qdck_l = ~qdck_l;

   function automatic logic model_cin();
      case (cin_sel_h)
         2'b00:   return 1'b0;
         2'b01:   return 1'b1;
         2'b10:   return m_nzvc[0];
         default: return cin_ext_h;
      endcase
   endfunction

   // c[n] = carry into nibble n from active-low p/g
   function automatic logic [8:0] ref_carry(input logic [7:0] pl, input logic [7:0] gl,
                                            input logic c0);
      logic [8:0] c;
      c[0] = c0;
      for (int i = 0; i < 8; i++) c[i + 1] = ~gl[i] | (~pl[i] & c[i]);
      return c;
   endfunction

   task automatic push_comb();
      logic [8:0] c;
      c = ref_carry(p_l, g_l, model_cin());
      exp_aluc_q.push_back(~c[7:0]);
   endtask

   task automatic push_edge();
      logic [8:0] c;
      logic       n, zn, v, cb;
      logic [3:0] nx;
      c = ref_carry(p_l, g_l, model_cin());
      if (d_size_h == 2'b00) begin
         n = wsign_h[0]; zn = wmuxz_h[0]; v = aluv_h[0]; cb = c[2];
      end else if (d_size_h == 2'b01) begin
         n = wsign_h[1]; zn = wmuxz_h[0] & wmuxz_h[1]; v = aluv_h[1]; cb = c[4];
      end else begin
         n = wsign_h[2]; zn = (wmuxz_h == 4'hF); v = aluv_h[3]; cb = c[8];
      end
      if (!reset_l) nx = 4'b0100;
      else if (cc_ld_h) nx = {n, zacc_h ? (zn & m_nzvc[2]) : zn, v, cb};
      else nx = m_nzvc;
      m_nzvc = nx;
      exp_cc_q.push_back(nx);
`ifdef ALUCC_STEP_CNT_EN
      if (!reset_l) m_cnt = 6'd0;
      else if (sc_ld_h) m_cnt = sc_d_h;
      else if (sc_dec_h && m_cnt != 6'd0) m_cnt = m_cnt - 6'd1;
      exp_scz_q.push_back(m_cnt == 6'd0);
`else
      exp_scz_q.push_back(1'b1);
`endif
   endtask

   task automatic tick();
      @(posedge qdck_l);
      #1;
   endtask

   task automatic test_reset();
      reset_l = 1'b0; cc_ld_h = 1'b1; sc_ld_h = 1'b1; sc_d_h = 6'd5;
      wmuxz_h = 4'h0; wsign_h = 3'b111; d_size_h = 2'b10;
      push_edge();
      tick();
      exp4 = exp_cc_q.pop_front();
      n_checks++;
      if (alu_nzvc_h !== exp4 || alu_nzvc_h !== 4'b0100) begin
         n_errors++; $display("FAIL reset_nzvc: got %b expected %b", alu_nzvc_h, exp4);
      end
      expb = exp_scz_q.pop_front();
      n_checks++;
      if (sc_zero_h !== expb || sc_zero_h !== 1'b1) begin
         n_errors++; $display("FAIL reset_sc_zero: got %b expected %b", sc_zero_h, expb);
      end
      reset_l = 1'b1; cc_ld_h = 1'b0; sc_ld_h = 1'b0; sc_d_h = 6'd0;
   endtask

   typedef struct {
      logic [7:0] p; logic [7:0] g; logic [1:0] cs; logic ce; logic [1:0] dsz;
      logic [7:0] ea; logic ec;
   } carry_row_t;

   task automatic test_carry();
      carry_row_t t[6];
      t[0] = '{8'h01, 8'hFE, 2'b00, 1'b0, 2'b10, 8'h01, 1'b1};
      t[1] = '{8'h00, 8'hFF, 2'b01, 1'b0, 2'b00, 8'h00, 1'b1};
      t[2] = '{8'hFF, 8'hFF, 2'b01, 1'b0, 2'b10, 8'hFE, 1'b0};
      t[3] = '{8'h00, 8'hFF, 2'b10, 1'b0, 2'b10, 8'hFF, 1'b0};
      t[4] = '{8'h00, 8'hFF, 2'b11, 1'b1, 2'b10, 8'h00, 1'b1};
      t[5] = '{8'h00, 8'hFF, 2'b10, 1'b0, 2'b01, 8'h00, 1'b1};
      cc_ld_h = 1'b1; zacc_h = 1'b0;
      for (int i = 0; i < 6; i++) begin
         p_l = t[i].p; g_l = t[i].g; cin_sel_h = t[i].cs; cin_ext_h = t[i].ce;
         d_size_h = t[i].dsz;
         push_comb();
         #1;
         exp8 = exp_aluc_q.pop_front();
         n_checks++;
         if (aluc_l !== exp8 || aluc_l !== t[i].ea) begin
            n_errors++; $display("FAIL carry_aluc[%0d]: got %h expected %h", i, aluc_l, t[i].ea);
         end
         push_edge();
         tick();
         exp4 = exp_cc_q.pop_front();
         n_checks++;
         if (alu_nzvc_h !== exp4 || alu_nzvc_h[0] !== t[i].ec) begin
            n_errors++; $display("FAIL carry_cc[%0d]: got %b expected %b", i, alu_nzvc_h, exp4);
         end
         void'(exp_scz_q.pop_front());
      end
      cc_ld_h = 1'b0; cin_sel_h = 2'b00;
   endtask

   typedef struct {
      logic [1:0] dsz; logic [3:0] wz; logic [2:0] ws; logic [3:0] av; logic [3:0] e;
   } size_row_t;

   task automatic test_size();
      size_row_t t[4];
      t[0] = '{2'b01, 4'b0011, 3'b010, 4'b0000, 4'b1100};
      t[1] = '{2'b10, 4'b0011, 3'b010, 4'b0000, 4'b0000};
      t[2] = '{2'b00, 4'b0001, 3'b001, 4'b0001, 4'b1110};
      t[3] = '{2'b11, 4'b1111, 3'b100, 4'b1000, 4'b1110};
      p_l = 8'hFF; g_l = 8'hFF; cin_sel_h = 2'b00; cc_ld_h = 1'b1; zacc_h = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d_size_h = t[i].dsz; wmuxz_h = t[i].wz; wsign_h = t[i].ws; aluv_h = t[i].av;
         push_edge();
         tick();
         exp4 = exp_cc_q.pop_front();
         n_checks++;
         if (alu_nzvc_h !== exp4 || alu_nzvc_h !== t[i].e) begin
            n_errors++; $display("FAIL size_cc[%0d]: got %b expected %b", i, alu_nzvc_h, t[i].e);
         end
         void'(exp_scz_q.pop_front());
      end
      cc_ld_h = 1'b0; aluv_h = 4'h0; wsign_h = 3'b000;
   endtask

   task automatic test_zacc();
      logic [3:0] wz[7] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
      logic       ld[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic       za[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       ez[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      d_size_h = 2'b10; p_l = 8'hFF; g_l = 8'hFF; cin_sel_h = 2'b00;
      for (int i = 0; i < 7; i++) begin
         wmuxz_h = wz[i]; cc_ld_h = ld[i]; zacc_h = za[i];
         push_edge();
         tick();
         exp4 = exp_cc_q.pop_front();
         n_checks++;
         if (alu_nzvc_h !== exp4 || alu_nzvc_h[2] !== ez[i]) begin
            n_errors++; $display("FAIL zacc[%0d]: got %b expected %b", i, alu_nzvc_h, exp4);
         end
         void'(exp_scz_q.pop_front());
      end
      cc_ld_h = 1'b0; zacc_h = 1'b0;
   endtask

   task automatic test_step_cnt();
      logic       rs[12] = '{1,1,1,1,1,1,1,1,1,0,1,1};
      logic       ld[12] = '{1,0,0,0,0,1,0,0,0,1,0,1};
      logic       dc[12] = '{0,1,1,1,1,1,1,1,1,1,1,0};
      logic [5:0] dv[12] = '{6'd3,0,0,0,0,6'd5,0,0,0,6'd9,0,6'd0};
      logic       ez[12] = '{0,0,0,1,1,0,0,0,0,1,1,1};
      for (int i = 0; i < 12; i++) begin
         reset_l = rs[i]; sc_ld_h = ld[i]; sc_dec_h = dc[i]; sc_d_h = dv[i];
         push_edge();
         tick();
         expb = exp_scz_q.pop_front();
`ifndef ALUCC_STEP_CNT_EN
         ez[i] = 1'b1;
`endif
         n_checks++;
         if (sc_zero_h !== expb || sc_zero_h !== ez[i]) begin
            n_errors++; $display("FAIL step_cnt[%0d]: got %b expected %b", i, sc_zero_h, ez[i]);
         end
         void'(exp_cc_q.pop_front());
      end
      reset_l = 1'b1; sc_ld_h = 1'b0; sc_dec_h = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         reset_l = ($urandom_range(0, 19) != 0);
         p_l = 8'($urandom); g_l = 8'($urandom);
         wmuxz_h = 4'($urandom); aluv_h = 4'($urandom); wsign_h = 3'($urandom);
         d_size_h = 2'($urandom); cin_sel_h = 2'($urandom); cin_ext_h = 1'($urandom);
         cc_ld_h = 1'($urandom); zacc_h = 1'($urandom);
         sc_ld_h = ($urandom_range(0, 7) == 0); sc_dec_h = 1'($urandom);
         sc_d_h = 6'($urandom_range(0, 7));
         push_comb();
         #1;
         exp8 = exp_aluc_q.pop_front();
         n_checks++;
         if (aluc_l !== exp8) begin
            n_errors++; $display("FAIL rand_aluc[%0d]: got %h expected %h", i, aluc_l, exp8);
         end
         push_edge();
         tick();
         exp4 = exp_cc_q.pop_front();
         n_checks++;
         if (alu_nzvc_h !== exp4) begin
            n_errors++; $display("FAIL rand_cc[%0d]: got %b expected %b", i, alu_nzvc_h, exp4);
         end
         expb = exp_scz_q.pop_front();
         n_checks++;
         if (sc_zero_h !== expb) begin
            n_errors++; $display("FAIL rand_sc_zero[%0d]: got %b expected %b", i, sc_zero_h, expb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_size();
      test_zacc();
      test_step_cnt();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
